// File: rtl/gv_pkg.sv
// Shared types and constants for the song note stream.
package gv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } loader_state_t;

  localparam int NOTE_W = 32;
  localparam logic [7:0] DEFAULT_START_BYTE = 8'hA5;

endpackage

// File: rtl/note_fifo.sv
// Synchronous note FIFO with combinational head and head+1 lookahead outputs.
module note_fifo
  import gv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       hwclk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [NOTE_W-1:0]          wdata,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [NOTE_W-1:0]          head,
  output logic [NOTE_W-1:0]          head2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NOTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_nxt;
  logic              push_ok;
  logic              pop_ok;

  // Both qualifiers look at the registered count: a pop never makes room
  // for a push in the same cycle, and a pop on an empty FIFO is dropped.
  assign push_ok = push && (count < CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge hwclk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign head  = (count != '0)      ? mem[rd_ptr] : '0;
  assign head2 = (count >= CW'(2))  ? mem[rd_nxt] : '0;

endmodule

// File: rtl/song_loader.sv
// UART byte receiver that frames a song into 32-bit note words and buffers
// them for the display's note1/note2 lookahead pair.
module song_loader
  import gv_pkg::*;
#(
  parameter int         DEPTH      = 8,
  parameter logic [7:0] START_BYTE = DEFAULT_START_BYTE
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic [7:0]        rxdata,
  input  logic              rxready,
  output logic              rxclk,
  input  logic              advance,
  output logic [NOTE_W-1:0] note1,
  output logic [NOTE_W-1:0] note2,
  output logic              valid1,
  output logic              valid2,
  output logic [7:0]        remaining,
  output logic              loading,
  output logic              frame_err,
  output loader_state_t     dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Byte handshake: a byte is taken when rxready is high, rxclk is low (the
  // cycle after an acknowledge is never sampled) and the byte would not
  // complete a word while the FIFO is full. The byte is latched on that edge,
  // rxclk is high the next cycle, and the FSM consumes the latched byte then.
  loader_state_t     state_q, state_d;
  logic [7:0]        byte_q;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        words_q, words_d;
  logic [23:0]       asm_q, asm_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              stall;
  logic              take;
  logic              push;
  logic              err_set;
  logic              err_clr;
  logic              rem_load;

  assign fifo_full = (fifo_count == CW'(DEPTH));
  assign stall     = (state_q == DATA) && (idx_q == 2'd3) && fifo_full;
  assign take      = rxready && !rxclk && !stall;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      idx_q   <= '0;
      words_q <= '0;
      asm_q   <= '0;
      rxclk   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      asm_q   <= asm_d;
      rxclk   <= take;
      if (take) byte_q <= rxdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    words_d  = words_q;
    asm_d    = asm_q;
    push     = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    rem_load = 1'b0;
    if (rxclk) begin
      case (state_q)
        IDLE: begin
          if (byte_q == START_BYTE) begin
            state_d = LEN;
            err_clr = 1'b1;
          end
        end
        LEN: begin
          if (byte_q == 8'd0) begin
            err_set = 1'b1;
            state_d = IDLE;
          end else begin
            words_d  = byte_q;
            rem_load = 1'b1;
            idx_d    = 2'd0;
            state_d  = DATA;
          end
        end
        DATA: begin
          asm_d = {asm_q[15:0], byte_q};
          if (idx_q == 2'd3) begin
            push    = 1'b1;
            idx_d   = 2'd0;
            words_d = words_q - 1'b1;
            if (words_q == 8'd1) state_d = IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      frame_err <= 1'b0;
      remaining <= '0;
    end else begin
      if (err_set)      frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (rem_load)
        remaining <= byte_q;
      else if (advance && valid1 && (remaining != 8'd0))
        remaining <= remaining - 8'd1;
    end
  end

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .hwclk (hwclk),
    .reset (reset),
    .push  (push),
    .wdata ({asm_q, byte_q}),
    .pop   (advance),
    .count (fifo_count),
    .head  (note1),
    .head2 (note2)
  );

  assign valid1    = (fifo_count != '0);
  assign valid2    = (fifo_count >= CW'(2));
  assign loading   = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/song_loader.md
# song_loader

Receives a song over the byte-wide UART receive port, frames it into 32-bit note words, and buffers them for the song display, which consumes them as its `note1`/`note2` lookahead pair. It is the writer side of the note stream: the display reads and advances, this block fills. It sits between the `rxdata`/`rxready`/`rxclk` pins of `top` and the display's note inputs.

## Interface

Parameters:

- `DEPTH`, default 8: note FIFO depth in words. Must be a power of 2 and at least 2.
- `START_BYTE`, default 8'hA5: frame start marker.

Ports:

- `hwclk` in 1: system clock.
- `reset` in 1: **synchronous, active-high** reset.
- `rxdata` in 8: received byte, valid while `rxready` is high.
- `rxready` in 1: a byte is available.
- `rxclk` out 1: one-cycle acknowledge pulse that consumes the current byte.
- `advance` in 1: display pops the head note.
- `note1` out 32: head note; 0 when the FIFO is empty.
- `note2` out 32: next note; 0 when fewer than 2 notes are held.
- `valid1`, `valid2` out 1: `note1` / `note2` hold real data.
- `remaining` out 8: notes of the current song not yet popped.
- `loading` out 1: a frame is in progress.
- `frame_err` out 1: sticky flag; cleared by reset or by the next `START_BYTE` accepted in IDLE.

## Operation

- Frame format: `START_BYTE`, then length `N` (1–255), then `4N` data bytes. Each word is big-endian (first byte lands in bits [31:24]).
- States:
  - **IDLE**: bytes other than `START_BYTE` are consumed and discarded. `START_BYTE` moves to LEN.
  - **LEN**: `N`=0 sets `frame_err` and returns to IDLE. Otherwise latch `N`, load `remaining`=`N`, and go to DATA.
  - **DATA**: shift bytes into a 32-bit assembly register with byte index 0–3. On index 3, push the word and decrement the words-to-receive count. When that count reaches 0, go to IDLE.
- Byte handshake:
  - The block samples `rxready` only when it can accept a byte, then drives `rxclk` high for exactly one cycle.
  - The cycle after an `rxclk` pulse is a guard cycle with no sampling. The peak rate is one byte per 2 cycles.
- Backpressure: in DATA, when the byte index is 3 and the FIFO is full, the byte is not acknowledged. `rxclk` stays low and the block waits.
- `START_BYTE` seen in DATA or LEN is treated as ordinary data. There is no resync mid-frame.
- Pop: `advance` while `valid1` is high removes the head and decrements `remaining` (saturating at 0). `advance` while empty is ignored.
- Simultaneous push and pop when full: the pop frees a slot but the push is **not** taken that cycle. Push eligibility is based on the registered count.
- Simultaneous push and pop when empty: the push lands and the pop is ignored.
- `remaining` counts popped notes only. It equals `N` minus the number of pops, independent of how many words have arrived.

## Timing

- Reset: all outputs are 0, the state is IDLE, the FIFO is empty, and `frame_err`=0. Reset mid-frame discards the partial word and all buffered notes.
- `rxclk` pulses in the cycle after `rxready` is sampled high.
- The pushed word is visible on `note1`/`note2` in the cycle after the `rxclk` pulse of its 4th byte.
- `note1`/`note2`/`valid*` update in the cycle after `advance`.
- `loading` is high from the cycle after `START_BYTE` is acknowledged until the cycle after the final data byte is acknowledged.

## Structure

- Shared package `gv_pkg`:
  - `loader_state_t` enum (IDLE, LEN, DATA).
  - `NOTE_W`=32.
  - Default `START_BYTE` constant.
- Sub-module `note_fifo`: synchronous FIFO, `DEPTH`×`NOTE_W`, with push, pop, count, and combinational head/head+1 outputs.
- The top-level FSM and byte assembler live in `song_loader`.

## Test plan

1. Reset, then the frame A5,02,11,22,33,44,55,66,77,88. Expect `note1`=32'h11223344 and `note2`=32'h55667788, both valid, `remaining`=2, and `loading`=0 after the last byte.
2. Starting from scenario 1, assert `advance` twice. Expect `note1`=32'h55667788 with `valid2`=0. After the second pop, `note1`=0, `valid1`=0, `remaining`=0. A third `advance` changes nothing.
3. With `DEPTH`=8, send `N`=10 without any pops. Expect 8 words buffered and `rxclk` held low on the 4th byte of word 9 while `rxready` stays high. After one `advance`, word 9 is accepted within 2 cycles.
4. Send bytes 00,FF then A5,00. Expect all 4 bytes acknowledged, `frame_err`=1, and the state back in IDLE. A following A5,01,DE,AD,BE,EF clears `frame_err` and gives `note1`=32'hDEADBEEF.
5. Hold `rxready` high continuously. Expect the `rxclk` pulses to be exactly 1 cycle wide and separated by at least 1 low cycle, with no byte counted twice.
6. Assert `reset` after 2 data bytes of a frame. Expect all outputs 0 on the next cycle. A new full frame then loads correctly.
